hazard_ctrl: RTL and testbench

- Central hazard and stall controller for the 5-stage RV32I pipeline (F/D/E/M/W).
- Generates forwarding selects for the E-stage ALU operands.
- Detects load-use hazards and squashes wrong-path instructions on taken branches and jumps.
- Sequences variable-latency data-memory accesses through a wait-state FSM, with a timeout flag and performance counters.

---
 rtl/hazard_ctrl.sv | 140 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller for a 5-stage RV32I pipeline: operand forwarding, load-use and branch squash, mem wait FSM.
// Stall/flush/forward outputs are combinational (same cycle); FSM, mem_err and perf counters update on clk.
module hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             PCSrcE,
  input  logic             MemAccessM,
  input  logic             dmem_ready,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             dmem_req,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int            WW  = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] TMO = WW'(TIMEOUT);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t          state;
  logic [WW-1:0]   wcnt;
  logic [WW-1:0]   wcnt_inc;
  logic            lw_haz;
  logic            mem_stall;

  // M result is younger than W, so it wins when both target the same register.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (RegWriteM && (RdM != 5'd0) && (RdM == rs))
      return 2'b10;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_comb begin
    ForwardAE = fwd_sel(Rs1E);
    ForwardBE = fwd_sel(Rs2E);
  end

  assign lw_haz    = MemtoRegE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
  assign mem_stall = MemAccessM && !dmem_ready;
  assign dmem_req  = MemAccessM;

  // Memory stall freezes E, so a resolved branch there is replayed on release.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (mem_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (lw_haz) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  assign wcnt_inc = (wcnt == TMO) ? TMO : wcnt + WW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      wcnt    <= '0;
      mem_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_stall) begin
            state <= WAIT;
            wcnt  <= WW'(1);
            if (TMO == WW'(1))
              mem_err <= 1'b1;
          end
        end
        WAIT: begin
          // Dropping the request mid-wait is illegal; recover to IDLE.
          if (!MemAccessM || dmem_ready) begin
            state <= IDLE;
            wcnt  <= '0;
          end else begin
            wcnt <= wcnt_inc;
            if (wcnt_inc == TMO)
              mem_err <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          wcnt  <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (StallF && (stall_cycles != {CNT_W{1'b1}}))
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (PCSrcE && !mem_stall && (flush_count != {CNT_W{1'b1}}))
        flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, load-use, branch squash, memory wait, timeout and reset.
module tb_hazard_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic        RegWriteM, RegWriteW, MemtoRegE, PCSrcE, MemAccessM, dmem_ready;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, dmem_req, mem_err;
  logic [15:0] stall_cycles, flush_count;

  int total = 0;
  int bad   = 0;

  hazard_ctrl #(.TIMEOUT(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
    .PCSrcE(PCSrcE), .MemAccessM(MemAccessM), .dmem_ready(dmem_ready),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .dmem_req(dmem_req), .mem_err(mem_err),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0; PCSrcE = 0;
    MemAccessM = 0; dmem_ready = 0;
  endtask

  // Packs {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW} for one-shot checks.
  function automatic logic [6:0] ctl();
    return {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
  endfunction

  initial begin
    clear_inputs();
    rst = 1'b1;
    tick();
    check("rst_mem_err", mem_err, 0);
    check("rst_stall_cnt", stall_cycles, 0);
    check("rst_flush_cnt", flush_count, 0);
    check("rst_ctl", ctl(), 7'b0000000);
    check("rst_req", dmem_req, 0);
    rst = 1'b0;

    // Forwarding
    RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5; Rs2E = 5; #1;
    check("fwdA_m_prio", ForwardAE, 2'b10);
    check("fwdB_m_prio", ForwardBE, 2'b10);
    RegWriteM = 0; #1;
    check("fwdA_w", ForwardAE, 2'b01);
    RegWriteM = 1; RdM = 0; RdW = 0; Rs1E = 0; Rs2E = 0; #1;
    check("fwdA_x0", ForwardAE, 2'b00);
    check("fwdB_x0", ForwardBE, 2'b00);
    RdM = 9; RdW = 7; Rs1E = 4; Rs2E = 7; #1;
    check("fwdA_none", ForwardAE, 2'b00);
    check("fwdB_w", ForwardBE, 2'b01);
    clear_inputs(); #1;

    // Load-use
    MemtoRegE = 1; RdE = 3; Rs2D = 3; #1;
    check("lw_ctl", ctl(), 7'b1100010);
    tick();
    clear_inputs(); #1;
    check("lw_release", ctl(), 7'b0000000);
    check("lw_stall_cnt", stall_cycles, 1);
    MemtoRegE = 1; RdE = 0; Rs1D = 0; #1;
    check("lw_x0", ctl(), 7'b0000000);
    clear_inputs(); #1;

    // Branch beats load-use
    MemtoRegE = 1; RdE = 3; Rs2D = 3; PCSrcE = 1; #1;
    check("br_lw_ctl", ctl(), 7'b0000110);
    tick();
    clear_inputs(); #1;
    check("br_flush_cnt", flush_count, 1);
    check("br_stall_cnt", stall_cycles, 1);

    // Memory wait: 3 stall cycles then ready
    MemAccessM = 1; dmem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("mw_ctl", ctl(), 7'b1111001);
      check("mw_req", dmem_req, 1);
      tick();
    end
    dmem_ready = 1; #1;
    check("mw_done_ctl", ctl(), 7'b0000000);
    check("mw_done_req", dmem_req, 1);
    tick();
    clear_inputs(); #1;
    check("mw_req_off", dmem_req, 0);
    check("mw_stall_cnt", stall_cycles, 4);

    // Branch held under memory stall
    MemAccessM = 1; dmem_ready = 0; PCSrcE = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("bms_ctl", ctl(), 7'b1111001);
      tick();
      check("bms_flush_cnt", flush_count, 1);
    end
    dmem_ready = 1; #1;
    check("bms_release", ctl(), 7'b0000110);
    tick();
    clear_inputs(); #1;
    check("bms_flush_inc", flush_count, 2);
    check("bms_stall_cnt", stall_cycles, 6);

    // Timeout at exactly 16 wait cycles
    MemAccessM = 1; dmem_ready = 0;
    for (int i = 0; i < 15; i++) tick();
    check("tmo_15", mem_err, 0);
    tick();
    check("tmo_16", mem_err, 1);
    dmem_ready = 1;
    tick();
    clear_inputs();
    tick();
    check("tmo_sticky", mem_err, 1);
    check("tmo_stall_cnt", stall_cycles, 22);

    // Reset mid-wait
    MemAccessM = 1; dmem_ready = 0;
    for (int i = 0; i < 5; i++) tick();
    rst = 1; #1;
    check("rst_comb_stall", StallF, 1);
    tick();
    check("rst2_mem_err", mem_err, 0);
    check("rst2_stall_cnt", stall_cycles, 0);
    check("rst2_flush_cnt", flush_count, 0);
    rst = 0;
    for (int i = 0; i < 15; i++) tick();
    check("rst2_wait_clr", mem_err, 0);
    check("rst2_stall15", stall_cycles, 15);
    tick();
    check("rst2_tmo", mem_err, 1);
    clear_inputs();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
